bpsk_demod: RTL and testbench
=============================

# bpsk_demod

Coherent BPSK demodulator: the receive-side counterpart of the team's 256-sample-per-cycle BPSK sine-table modulator. It accepts signed 16-bit baseband samples, correlates each symbol of one carrier period (256 samples) against the same internal Q15 sine table, and emits one hard bit plus a signed soft metric per symbol. It sits between the sample source (ADC model or looped-back modulator output) and the bit sink.

## Interface
- SOFT_SHIFT, 23: arithmetic right shift applied to the symbol accumulator to form `soft_out`.
- THRESH, 4096: low-confidence threshold on `|soft_out|`.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- sample_in  input  16  signed received sample.
- sample_valid  input  1  `sample_in` is accepted on this rising edge.
- sync  input  1  qualified by `sample_valid`; marks the current sample as carrier phase 0.
- bit_out  output  1  hard decision: 1 when accumulator ≥ 0, else 0.
- soft_out  output  16  signed `acc >>> SOFT_SHIFT`, saturated to [-32768, 32767].
- bit_valid  output  1  one-cycle strobe; `bit_out`, `soft_out` and `low_conf` are valid while it is high.
- low_conf  output  1  `|soft_out| < THRESH` for the current symbol.
- lowconf_count  output  16  saturating count of low-confidence symbols (see Configuration).
- locked  output  1  high in RUN state.

## Operation
- Sine table: 256 entries, `sine[i] = rtoi(sin(2·3.14159·i/256)·32767)`, identical to the modulator's.
- States: IDLE (`locked`=0, samples ignored unless `sync`) and RUN (`locked`=1).
- IDLE → RUN on accepted sample with `sync`=1; that sample is phase 0.
- In RUN, every accepted sample uses phase index `ph` (8-bit), then `ph` increments and wraps 255 → 0.
- `sync` in RUN: the current sample becomes phase 0. The partial accumulator is discarded, and no `bit_valid` is produced for the aborted symbol.
- Pipeline stage 1: `prod = sample_in * sine[ph]` (32-bit signed), registered with a tag recording first/last sample of the symbol.
- Stage 2: a 40-bit signed `acc` is loaded with `prod` on first sample and adds `prod` otherwise. On the last sample (ph=255), the final sum `acc+prod` drives the decision registers.
- Decision: `bit_out` = final sum ≥ 0. `soft_out` = final sum `>>> SOFT_SHIFT`, saturated. `low_conf` = `|soft_out| < THRESH`, with |-32768| treated as 32768.
- Outputs hold their value until the next decision. `bit_valid` is high only in the decision cycle.
- Gaps in `sample_valid` stall the phase counter and pipeline advance; no timeout.

## Timing
- Reset values: `bit_out`=0, `soft_out`=0, `bit_valid`=0, `low_conf`=0, `lowconf_count`=0, `locked`=0. On reset, state=IDLE, `ph`=0, `acc`=0, and pipeline valids are cleared.
- Latency: `bit_valid` is high for the clock cycle following the second rising edge after the edge that accepts the ph=255 sample, provided `sample_valid` is continuous.
- The pipeline drains the last-sample tag even if `sample_valid` drops right after ph=255.
- Back-to-back symbols at full rate give one `bit_valid` every 256 cycles.
- Reset mid-symbol: all state is cleared immediately, and no strobe is issued for the pending symbol.
- `sync` together with an in-flight last-sample product: the in-flight symbol still completes and strobes. The new symbol starts cleanly.

## Configuration
- `BPSK_DEMOD_ERRCNT_EN` defined: `lowconf_count` increments on each `bit_valid` with `low_conf`=1, saturating at 65535, and clears only on reset.
- Not defined: `lowconf_count` is tied to 0 and the counter logic is absent. `low_conf` still operates.

## Test plan
- Reset, then `sync` plus 256 samples of `sine[i]` → `bit_out`=1, `soft_out` ≈ +16380 (±8), `low_conf`=0, `locked`=1.
- 256 samples of `-sine[i]` → `bit_out`=0, `soft_out` ≈ -16380, exactly one `bit_valid` 2 cycles after the last sample.
- Looped modulator pattern 1,0,0,1 with continuous valid → decisions 1,0,0,1 at 256-cycle spacing, with no strobe before the first `sync`.
- All-zero samples for one symbol → `bit_out`=1, `soft_out`=0, `low_conf`=1. With the macro, `lowconf_count`=1; without it, `lowconf_count`=0.
- `sync` reasserted at ph=100 → no strobe for the aborted symbol; the next strobe comes 256 samples after the resync.
- Reset asserted at ph=200, then released → all outputs at reset values, `locked`=0, and samples ignored until `sync`.

Source files
------------

// File: rtl/bpsk_demod.sv
// bpsk_demod: coherent BPSK demodulator, one carrier period (256 samples) per symbol.
// Each accepted sample is multiplied by the matching Q15 sine-table entry and
// summed over the symbol. The symbol sum gives a hard bit and a saturated soft metric.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   sample_in       signed 16-bit received sample
//   sample_valid    sample_in accepted on this rising edge
//   sync            with sample_valid: current sample is carrier phase 0
//   bit_out         hard decision (1 when symbol sum >= 0)
//   soft_out        symbol sum >>> SOFT_SHIFT, saturated to 16 bits signed
//   bit_valid       one-cycle strobe marking a new decision
//   low_conf        |soft_out| < THRESH
//   lowconf_count   saturating count of low-confidence decisions
//   locked          high while in RUN
//
// Build option: define BPSK_DEMOD_ERRCNT_EN to include the low-confidence
// counter; otherwise lowconf_count is tied to 0.
module bpsk_demod #(
    parameter int unsigned SOFT_SHIFT = 23,
    parameter int unsigned THRESH     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        sync,
    output logic        bit_out,
    output logic [15:0] soft_out,
    output logic        bit_valid,
    output logic        low_conf,
    output logic [15:0] lowconf_count,
    output logic        locked
);

    localparam int unsigned SAMP_W = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned PH_W   = 8;
    localparam int unsigned MAG_W  = SAMP_W + 1;
    localparam int unsigned TBL_N  = 256;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(32768);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Q15 sine entry, same formula as the modulator's table
    function automatic logic signed [SAMP_W-1:0] sine_val(input int idx);
        return SAMP_W'($rtoi($sin(2.0 * 3.14159 * real'(idx) / 256.0) * 32767.0));
    endfunction

    logic signed [SAMP_W-1:0] sine_rom [TBL_N];

    // Constant table; elaborates to a ROM
    for (genvar g = 0; g < TBL_N; g++) begin : g_sine
        assign sine_rom[g] = sine_val(g);
    end

    state_t            state, state_nxt;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_eff_c;
    logic              accept_c;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  fin_sum;
    logic                     fin_valid;

    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [SAMP_W-1:0] soft_sat_c;
    logic signed [MAG_W-1:0]  soft_ext_c;
    logic [MAG_W-1:0]         mag_c;
    logic                     low_c;

    // Next-state and acceptance; sync forces the current sample to phase 0
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        ph_eff_c  = ph;
        case (state)
            IDLE: begin
                if (sample_valid && sync) begin
                    state_nxt = RUN;
                    accept_c  = 1'b1;
                    ph_eff_c  = '0;
                end
            end
            RUN: begin
                if (sample_valid) begin
                    accept_c = 1'b1;
                    if (sync) begin
                        ph_eff_c = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, phase counter and lock indication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ph     <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt == RUN);
            if (accept_c) begin
                ph <= ph_eff_c + PH_W'(1);
            end
        end
    end

    assign prod_c = $signed(sample_in) * sine_rom[ph_eff_c];

    // Stage 1: product plus first/last-of-symbol tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_prod  <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_prod  <= prod_c;
                s1_first <= (ph_eff_c == '0);
                s1_last  <= (ph_eff_c == '1);
            end
        end
    end

    // A first-sample tag restarts the sum, which also discards any aborted partial symbol
    assign sum_c = (s1_first ? '0 : acc) + ACC_W'(s1_prod);

    // Stage 2: accumulate; capture the completed symbol sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            fin_sum   <= '0;
            fin_valid <= 1'b0;
        end else begin
            fin_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= sum_c;
                if (s1_last) begin
                    fin_sum <= sum_c;
                end
            end
        end
    end

    // Soft metric saturation and confidence test; |-32768| needs the extra magnitude bit
    always_comb begin
        shifted_c = fin_sum >>> SOFT_SHIFT;
        if (shifted_c > SAT_HI) begin
            soft_sat_c = SAMP_W'(SAT_HI);
        end else if (shifted_c < SAT_LO) begin
            soft_sat_c = SAMP_W'(SAT_LO);
        end else begin
            soft_sat_c = SAMP_W'(shifted_c);
        end
        soft_ext_c = MAG_W'(soft_sat_c);
        mag_c      = soft_ext_c[MAG_W-1] ? MAG_W'(-soft_ext_c) : MAG_W'(soft_ext_c);
        low_c      = (mag_c < MAG_W'(THRESH));
    end

    // Decision registers hold until the next symbol completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_out   <= 1'b0;
            soft_out  <= '0;
            bit_valid <= 1'b0;
            low_conf  <= 1'b0;
        end else begin
            bit_valid <= fin_valid;
            if (fin_valid) begin
                bit_out  <= ~fin_sum[ACC_W-1];
                soft_out <= soft_sat_c;
                low_conf <= low_c;
            end
        end
    end

`ifdef BPSK_DEMOD_ERRCNT_EN
    // Saturating low-confidence counter, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lowconf_count <= '0;
        end else if (fin_valid && low_c && (lowconf_count != '1)) begin
            lowconf_count <= lowconf_count + 16'd1;
        end
    end
`else
    assign lowconf_count = '0;
`endif

endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod: directed bench for bpsk_demod with a scoreboard of expected decisions.
module tb_bpsk_demod;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sync;
    logic        bit_out;
    logic [15:0] soft_out;
    logic        bit_valid;
    logic        low_conf;
    logic [15:0] lowconf_count;
    logic        locked;

    typedef struct {
        logic              b;
        logic signed [15:0] s;
        logic              l;
        int                due;
    } exp_t;

    exp_t   sb[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;
    int     sine_tb[256];
    bit     run_m       = 1'b0;
    int     ph_m        = 0;
    longint sum_m       = 0;
    int     low_cnt_m   = 0;

    bpsk_demod #(.SOFT_SHIFT(23), .THRESH(4096)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sync          (sync),
        .bit_out       (bit_out),
        .soft_out      (soft_out),
        .bit_valid     (bit_valid),
        .low_conf      (low_conf),
        .lowconf_count (lowconf_count),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef BPSK_DEMOD_ERRCNT_EN
        return low_cnt_m;
`else
        return 0;
`endif
    endfunction

    // One clock; outputs sampled 1 ns after the edge and matched against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (bit_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", bit_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                if (e.l) low_cnt_m++;
                chk("strobe_cycle", cyc, e.due);
                chk("bit_out", bit_out, e.b);
                chk("soft_out", $signed(soft_out), e.s);
                chk("low_conf", low_conf, e.l);
                chk("lowconf_count", lowconf_count, exp_count());
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("missed_strobe", bit_valid, 1'b1);
            void'(sb.pop_front());
        end
    endtask

    task automatic push_expect(input longint sum, input int due);
        exp_t   e;
        longint sh;
        sh = sum >>> 23;
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
        e.b   = (sum >= 0);
        e.s   = 16'(sh);
        e.l   = ((sh < 0) ? -sh : sh) < 4096;
        e.due = due;
        sb.push_back(e);
    endtask

    // Drive one valid sample; reference model tracks phase and symbol sum
    task automatic send(input int s, input bit sy);
        longint p;
        sample_in    = 16'(s);
        sample_valid = 1'b1;
        sync         = sy;
        if (sy) begin
            run_m = 1'b1;
            ph_m  = 0;
        end
        if (run_m) begin
            p     = longint'(s) * longint'(sine_tb[ph_m]);
            sum_m = (ph_m == 0) ? p : sum_m + p;
            if (ph_m == 255) push_expect(sum_m, cyc + 3);
            ph_m = (ph_m + 1) % 256;
        end
        tick();
        sample_valid = 1'b0;
        sync         = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        sync         = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_sym(input int sign, input bit sy);
        for (int i = 0; i < 256; i++) send(sign * sine_tb[i], sy && (i == 0));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_bit_out"}, bit_out, 1'b0);
        chk({pfx, "_soft_out"}, soft_out, 16'd0);
        chk({pfx, "_bit_valid"}, bit_valid, 1'b0);
        chk({pfx, "_low_conf"}, low_conf, 1'b0);
        chk({pfx, "_lowconf_count"}, lowconf_count, 16'd0);
        chk({pfx, "_locked"}, locked, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            sine_tb[i] = $rtoi($sin(2.0 * 3.14159 * real'(i) / 256.0) * 32767.0);

        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        sync         = 1'b0;
        idle(3);
        chk_reset_outputs("por");
        reset = 1'b0;
        idle(2);

        // Samples before the first sync are ignored
        for (int i = 0; i < 40; i++) send(sine_tb[i], 1'b0);
        idle(3);
        chk("locked_before_sync", locked, 1'b0);

        // Sync + sine symbol, then negated symbol, then pattern 1,0,0,1
        send(sine_tb[0], 1'b1);
        chk("locked_after_sync", locked, 1'b1);
        for (int i = 1; i < 256; i++) send(sine_tb[i], 1'b0);
        send_sym(-1, 1'b0);
        send_sym(1, 1'b0);
        send_sym(-1, 1'b0);
        send_sym(-1, 1'b0);
        send_sym(1, 1'b0);
        idle(4);
        chk("soft_near_16380", ($signed(soft_out) >= 16372) && ($signed(soft_out) <= 16388), 1'b1);

        // All-zero symbol: zero sum decides 1 with low confidence
        for (int i = 0; i < 256; i++) send(0, 1'b0);
        idle(4);
        chk("zero_low_conf_held", low_conf, 1'b1);

        // Resync at ph=100 aborts the partial symbol; a gap stalls the new one
        for (int i = 0; i < 100; i++)
            send(sine_tb[i] / 2 + int'($urandom_range(0, 8000)) - 4000, i == 0);
        for (int i = 0; i < 256; i++) begin
            if (i == 50) idle(3);
            send(-sine_tb[i] / 2 + int'($urandom_range(0, 8000)) - 4000, i == 0);
        end
        idle(4);

        // Asynchronous reset at ph=200
        send_sym(1, 1'b0);
        for (int i = 0; i < 200; i++) send(sine_tb[i], 1'b0);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        run_m     = 1'b0;
        ph_m      = 0;
        low_cnt_m = 0;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) send(sine_tb[i % 256], 1'b0);
        idle(3);
        chk("locked_after_reset", locked, 1'b0);
        send_sym(-1, 1'b1);
        idle(5);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
